// File: rtl/pc_flow_controller_pkg.sv
// Shared constants for the program-counter flow controller: opcodes, FSM states, default widths.
package pc_flow_controller_pkg;

  localparam int unsigned PC_WIDTH_DFLT    = 8;
  localparam int unsigned STACK_DEPTH_DFLT = 4;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_GOTO = 3'b001;
  localparam logic [2:0] OP_BRZ  = 3'b010;
  localparam logic [2:0] OP_BRC  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StFlush  = 2'b01,
    StHalted = 2'b10
  } state_e;

endpackage

// File: rtl/pc_flow_controller_if.sv
// Command/flag inputs from the decoder and control outputs to the program counter.
interface pc_flow_controller_if
  import pc_flow_controller_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DFLT
);

  logic                cmd_valid;
  logic [2:0]          cmd_op;
  logic [PC_WIDTH-1:0] cmd_arg;
  logic                flag_z;
  logic                flag_c;
  logic                resume;
  logic [PC_WIDTH-1:0] pc;
  logic                wr_en;
  logic                add_offset;
  logic [PC_WIDTH-1:0] counteradress;
  logic                flush;
  logic                halted;
  logic                err_ovf;
  logic                err_unf;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, flag_z, flag_c, resume, pc,
    input  wr_en, add_offset, counteradress, flush, halted, err_ovf, err_unf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, flag_z, flag_c, resume, pc,
    output wr_en, add_offset, counteradress, flush, halted, err_ovf, err_unf
  );

endinterface

// File: rtl/pc_flow_controller_ret_stack.sv
// Return-address LIFO. sp carries one extra bit so full and empty are distinct.
module pc_flow_controller_ret_stack
  import pc_flow_controller_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DFLT,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DFLT
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH);

  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PtrW:0]       sp_q;
  logic [PtrW-1:0]     wr_idx;
  logic [PtrW-1:0]     top_idx;

  assign wr_idx  = sp_q[PtrW-1:0];
  assign top_idx = sp_q[PtrW-1:0] - PtrW'(1);
  assign full    = (sp_q == (PtrW+1)'(STACK_DEPTH));
  assign empty   = (sp_q == '0);
  assign top     = mem_q[top_idx];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sp_q <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !full) begin
      mem_q[wr_idx] <= push_data;
      sp_q          <= sp_q + (PtrW+1)'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - (PtrW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_flow_controller.sv
// Program-counter sequencing FSM: jumps, branches, call/return, halt and post-transfer flush.
module pc_flow_controller
  import pc_flow_controller_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DFLT,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DFLT
) (
  input logic                  clk,
  input logic                  res_n,
  pc_flow_controller_if.slave  bus
);

  state_e              state_q, state_d;
  logic                err_ovf_q, err_unf_q;
  logic                set_ovf, set_unf, clr_err;
  logic                push, pop;
  logic                stk_full, stk_empty;
  logic [PC_WIDTH-1:0] stk_top;
  logic [PC_WIDTH-1:0] ret_addr;
  logic                wr_en, add_offset, flush;
  logic [PC_WIDTH-1:0] tgt;

  assign ret_addr = bus.pc + PC_WIDTH'(1);

  pc_flow_controller_ret_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .res_n     (res_n),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= StRun;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr_err) begin
        err_ovf_q <= 1'b0;
        err_unf_q <= 1'b0;
      end else begin
        if (set_ovf) err_ovf_q <= 1'b1;
        if (set_unf) err_unf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    add_offset = 1'b0;
    tgt        = '0;
    flush      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    clr_err    = 1'b0;
    // Everything stays quiet while reset is asserted, including the Mealy outputs.
    if (res_n) begin
      unique case (state_q)
        StRun: begin
          if (bus.cmd_valid) begin
            unique case (bus.cmd_op)
              OP_GOTO: begin
                wr_en   = 1'b1;
                tgt     = bus.cmd_arg;
                state_d = StFlush;
              end
              OP_BRZ, OP_BRC: begin
                if ((bus.cmd_op == OP_BRZ) ? bus.flag_z : bus.flag_c) begin
                  wr_en      = 1'b1;
                  add_offset = 1'b1;
                  tgt        = bus.cmd_arg;
                  state_d    = StFlush;
                end
              end
              OP_CALL: begin
                wr_en = 1'b1;
                if (!stk_full) begin
                  push    = 1'b1;
                  tgt     = bus.cmd_arg;
                  state_d = StFlush;
                end else begin
                  set_ovf = 1'b1;
                  tgt     = bus.pc;
                  state_d = StHalted;
                end
              end
              OP_RET: begin
                if (!stk_empty) begin
                  pop     = 1'b1;
                  wr_en   = 1'b1;
                  tgt     = stk_top;
                  state_d = StFlush;
                end else begin
                  // No hold on underflow: the counter still advances this cycle.
                  set_unf = 1'b1;
                  state_d = StHalted;
                end
              end
              OP_HALT: begin
                wr_en   = 1'b1;
                tgt     = bus.pc;
                state_d = StHalted;
              end
              default: ;
            endcase
          end
        end
        StFlush: begin
          flush   = 1'b1;
          state_d = StRun;
        end
        StHalted: begin
          wr_en = 1'b1;
          tgt   = bus.pc;
          if (bus.resume) begin
            clr_err = 1'b1;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  assign bus.wr_en         = wr_en;
  assign bus.add_offset    = add_offset;
  assign bus.counteradress = tgt;
  assign bus.flush         = flush;
  assign bus.halted        = (state_q == StHalted);
  assign bus.err_ovf       = err_ovf_q;
  assign bus.err_unf       = err_unf_q;

endmodule

// File: tb/tb_pc_flow_controller.sv
// Directed bench: pc_flow_controller driving a behavioural program counter.
module tb_pc_flow_controller;
  import pc_flow_controller_pkg::*;

  logic clk;
  logic res_n;
  logic [7:0] pc_q;
  int n_vec;
  int n_err;

  pc_flow_controller_if #(.PC_WIDTH(8)) bus ();

  pc_flow_controller #(
    .PC_WIDTH    (8),
    .STACK_DEPTH (4)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: reset to FF, load/offset on wr_en, otherwise increment.
  always @(posedge clk or negedge res_n) begin
    if (!res_n) pc_q <= 8'hFF;
    else if (bus.wr_en) pc_q <= bus.add_offset ? pc_q + bus.counteradress + 8'd1
                                               : bus.counteradress;
    else pc_q <= pc_q + 8'd1;
  end
  assign bus.pc = pc_q;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic wr, input logic ao,
                         input logic [7:0] adr, input logic fl);
    chk1({tag, ".wr_en"}, bus.wr_en, wr);
    chk1({tag, ".add_offset"}, bus.add_offset, ao);
    chk8({tag, ".counteradress"}, bus.counteradress, adr);
    chk1({tag, ".flush"}, bus.flush, fl);
  endtask

  // Apply inputs just after the falling edge, then let combinational outputs settle.
  task automatic go(input logic v, input logic [2:0] op, input logic [7:0] arg,
                    input logic z, input logic c, input logic r);
    @(negedge clk);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.flag_z    = z;
    bus.flag_c    = c;
    bus.resume    = r;
    #1;
  endtask

  task automatic idle();
    go(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] call_tgt [4];
  logic [7:0] ret_tgt  [4];
  logic [7:0] ret_pc   [4];
  logic [7:0] exp_pc;

  initial begin
    n_vec = 0;
    n_err = 0;
    res_n = 1'b0;
    call_tgt = '{8'h50, 8'h60, 8'h70, 8'h30};
    ret_tgt  = '{8'h72, 8'h62, 8'h52, 8'h23};
    ret_pc   = '{8'h31, 8'h73, 8'h63, 8'h53};

    // Commands presented during reset must not reach the outputs.
    go(1'b1, OP_GOTO, 8'h55, 1'b1, 1'b1, 1'b1);
    chk_out("rst", 1'b0, 1'b0, 8'h00, 1'b0);
    chk1("rst.halted", bus.halted, 1'b0);
    chk1("rst.err_ovf", bus.err_ovf, 1'b0);
    chk1("rst.err_unf", bus.err_unf, 1'b0);
    chk8("rst.pc", pc_q, 8'hFF);

    @(negedge clk);
    res_n = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.resume    = 1'b0;
    #1;
    chk8("idle.pc_ff", pc_q, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk8("idle.pc", pc_q, 8'(i));
      chk1("idle.wr_en", bus.wr_en, 1'b0);
    end
    idle();
    idle();

    go(1'b1, OP_GOTO, 8'h40, 1'b0, 1'b0, 1'b0);
    chk8("goto.pc", pc_q, 8'h05);
    chk_out("goto", 1'b1, 1'b0, 8'h40, 1'b0);
    go(1'b1, OP_GOTO, 8'h99, 1'b0, 1'b0, 1'b0);
    chk8("goto_flush.pc", pc_q, 8'h40);
    chk_out("goto_flush", 1'b0, 1'b0, 8'h00, 1'b1);
    go(1'b1, OP_GOTO, 8'h0F, 1'b0, 1'b0, 1'b0);
    chk8("after_flush.pc", pc_q, 8'h41);
    chk_out("goto2", 1'b1, 1'b0, 8'h0F, 1'b0);
    idle();
    chk1("goto2_flush", bus.flush, 1'b1);

    go(1'b1, OP_BRZ, 8'hFE, 1'b1, 1'b0, 1'b0);
    chk8("brz_t.pc", pc_q, 8'h10);
    chk_out("brz_t", 1'b1, 1'b1, 8'hFE, 1'b0);
    idle();
    chk8("brz_t.target", pc_q, 8'h0F);
    chk1("brz_t.flush", bus.flush, 1'b1);
    go(1'b1, OP_BRZ, 8'hFE, 1'b0, 1'b1, 1'b0);
    chk8("brz_nt.pc", pc_q, 8'h10);
    chk_out("brz_nt", 1'b0, 1'b0, 8'h00, 1'b0);
    go(1'b1, OP_BRC, 8'h05, 1'b0, 1'b1, 1'b0);
    chk8("brz_nt.next", pc_q, 8'h11);
    chk_out("brc_t", 1'b1, 1'b1, 8'h05, 1'b0);
    idle();
    chk8("brc_t.target", pc_q, 8'h17);
    go(1'b1, OP_BRC, 8'h05, 1'b1, 1'b0, 1'b0);
    chk_out("brc_nt", 1'b0, 1'b0, 8'h00, 1'b0);
    go(1'b1, OP_GOTO, 8'h1F, 1'b0, 1'b0, 1'b0);
    chk8("brc_nt.next", pc_q, 8'h19);
    idle();

    go(1'b1, OP_CALL, 8'h80, 1'b0, 1'b0, 1'b0);
    chk8("call.pc", pc_q, 8'h20);
    chk_out("call", 1'b1, 1'b0, 8'h80, 1'b0);
    idle();
    chk8("call.target", pc_q, 8'h80);
    chk1("call.flush", bus.flush, 1'b1);
    repeat (4) idle();
    go(1'b1, OP_RET, 8'h00, 1'b0, 1'b0, 1'b0);
    chk8("ret.pc", pc_q, 8'h85);
    chk_out("ret", 1'b1, 1'b0, 8'h21, 1'b0);
    idle();
    chk8("ret.target", pc_q, 8'h21);

    exp_pc = 8'h22;
    for (int i = 0; i < 4; i++) begin
      go(1'b1, OP_CALL, call_tgt[i], 1'b0, 1'b0, 1'b0);
      chk8("call4.pc", pc_q, exp_pc);
      chk_out("call4", 1'b1, 1'b0, call_tgt[i], 1'b0);
      idle();
      exp_pc = call_tgt[i] + 8'd1;
    end
    go(1'b1, OP_CALL, 8'h90, 1'b0, 1'b0, 1'b0);
    chk8("ovf.pc", pc_q, 8'h31);
    chk_out("ovf.hold", 1'b1, 1'b0, 8'h31, 1'b0);
    go(1'b1, OP_GOTO, 8'h77, 1'b0, 1'b0, 1'b0);
    chk8("ovf.frozen", pc_q, 8'h31);
    chk1("ovf.halted", bus.halted, 1'b1);
    chk1("ovf.err_ovf", bus.err_ovf, 1'b1);
    chk_out("ovf.ignore", 1'b1, 1'b0, 8'h31, 1'b0);
    go(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_out("ovf.resume_hold", 1'b1, 1'b0, 8'h31, 1'b0);

    // Stack survives the halt; unwind all four frames.
    for (int i = 0; i < 4; i++) begin
      go(1'b1, OP_RET, 8'h00, 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        chk1("resume.halted", bus.halted, 1'b0);
        chk1("resume.err_ovf", bus.err_ovf, 1'b0);
      end
      chk8("ret4.pc", pc_q, ret_pc[i]);
      chk_out("ret4", 1'b1, 1'b0, ret_tgt[i], 1'b0);
      idle();
      chk8("ret4.target", pc_q, ret_tgt[i]);
    end

    go(1'b1, OP_RET, 8'h00, 1'b0, 1'b0, 1'b0);
    chk8("unf.pc", pc_q, 8'h24);
    chk_out("unf", 1'b0, 1'b0, 8'h00, 1'b0);
    idle();
    chk8("unf.next", pc_q, 8'h25);
    chk1("unf.halted", bus.halted, 1'b1);
    chk1("unf.err_unf", bus.err_unf, 1'b1);
    chk_out("unf.hold", 1'b1, 1'b0, 8'h25, 1'b0);
    go(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0, 1'b1);
    chk8("unf.frozen", pc_q, 8'h25);
    idle();
    chk1("unf.resumed", bus.halted, 1'b0);
    chk1("unf.cleared", bus.err_unf, 1'b0);
    chk8("unf.resume_pc", pc_q, 8'h25);

    go(1'b1, OP_CALL, 8'h32, 1'b0, 1'b0, 1'b0);
    chk8("resume.incr", pc_q, 8'h26);
    idle();
    go(1'b1, OP_HALT, 8'h00, 1'b0, 1'b0, 1'b0);
    chk8("halt.pc", pc_q, 8'h33);
    chk_out("halt", 1'b1, 1'b0, 8'h33, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk8("halt.frozen", pc_q, 8'h33);
      chk1("halt.halted", bus.halted, 1'b1);
    end

    // Asynchronous reset in the middle of a halted phase.
    #2;
    res_n = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_GOTO;
    bus.cmd_arg   = 8'hAA;
    #1;
    chk_out("rst2", 1'b0, 1'b0, 8'h00, 1'b0);
    chk1("rst2.halted", bus.halted, 1'b0);
    chk8("rst2.pc", pc_q, 8'hFF);
    idle();
    res_n = 1'b1;
    #1;
    chk8("rst2.pc_hold", pc_q, 8'hFF);
    go(1'b1, OP_RET, 8'h00, 1'b0, 1'b0, 1'b0);
    chk8("rst2.run", pc_q, 8'h00);
    chk_out("rst2.empty_ret", 1'b0, 1'b0, 8'h00, 1'b0);
    idle();
    chk1("rst2.unf", bus.err_unf, 1'b1);
    chk1("rst2.unf_halted", bus.halted, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
